// File: rtl/mux_drive_seq.sv
// rtl/mux_drive_seq.sv - pattern FIFO played back as timed a/b/s drive to a 2:1 mux
// Optional abort input enabled by defining MUX_DRIVE_SEQ_ABORT_EN.
module mux_drive_seq #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_pat,
    input  logic [HOLD_W-1:0]            in_hold,
    input  logic                         start,
`ifdef MUX_DRIVE_SEQ_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         a,
    output logic                         b,
    output logic                         s,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]        drv_q, drv_d;
    logic              done_q, done_d;

    logic [2:0]        pat_mem_q  [DEPTH];
    logic [HOLD_W-1:0] hold_mem_q [DEPTH];

    logic push;
    logic pop;
    logic flush;

    // in_ready depends only on registered occupancy, never on in_valid or start.
    assign in_ready = (count_q < CNT_W'(DEPTH));

    always_comb begin
        push       = in_valid && in_ready;
        pop        = 1'b0;
        flush      = 1'b0;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        drv_d      = drv_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (count_q != '0)) begin
                    pop     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else if (count_q != '0) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            drv_d      = pat_mem_q[rd_ptr_q];
            hold_cnt_d = hold_mem_q[rd_ptr_q];
        end

`ifdef MUX_DRIVE_SEQ_ABORT_EN
        if (abort && (state_q == RUN)) begin
            flush      = 1'b1;
            pop        = 1'b0;
            state_d    = IDLE;
            hold_cnt_d = '0;
            drv_d      = 3'b000;
            done_d     = 1'b0;
        end
`endif

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A flush discards everything, including an entry pushed on the same edge.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_cnt_q <= '0;
            drv_q      <= 3'b000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_cnt_q <= hold_cnt_d;
            drv_q      <= drv_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pat_mem_q[wr_ptr_q]  <= in_pat;
            hold_mem_q[wr_ptr_q] <= in_hold;
        end
    end

    assign a     = drv_q[2];
    assign b     = drv_q[1];
    assign s     = drv_q[0];
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_mux_drive_seq.sv
// tb/tb_mux_drive_seq.sv - directed vector table plus randomized run against a queue model
module tb_mux_drive_seq;

    localparam int DEPTH  = 8;
    localparam int HOLD_W = 8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_pat;
    logic [7:0] in_hold;
    logic       start;
    logic       abort;
    logic       a, b, s, busy, done;
    logic [3:0] count;

    mux_drive_seq #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pat   (in_pat),
        .in_hold  (in_hold),
        .start    (start),
`ifdef MUX_DRIVE_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .a        (a),
        .b        (b),
        .s        (s),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [2:0] p;
        logic [7:0] h;
        logic       st;
        logic       ab;
        logic [2:0] e_abs;
        logic       e_busy;
        logic       e_done;
        logic       e_rdy;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[128];
    int   nvec_tbl = 0;
    int   nvec     = 0;
    int   nerr     = 0;

    task automatic add(input logic r, input logic v, input logic [2:0] p, input logic [7:0] h,
                       input logic st, input logic ab, input logic [2:0] e_abs,
                       input logic e_busy, input logic e_done, input int e_cnt);
        vecs[nvec_tbl].r      = r;
        vecs[nvec_tbl].v      = v;
        vecs[nvec_tbl].p      = p;
        vecs[nvec_tbl].h      = h;
        vecs[nvec_tbl].st     = st;
        vecs[nvec_tbl].ab     = ab;
        vecs[nvec_tbl].e_abs  = e_abs;
        vecs[nvec_tbl].e_busy = e_busy;
        vecs[nvec_tbl].e_done = e_done;
        vecs[nvec_tbl].e_rdy  = (e_cnt < DEPTH);
        vecs[nvec_tbl].e_cnt  = 4'(e_cnt);
        nvec_tbl++;
    endtask

    task automatic apply(input logic r, input logic v, input logic [2:0] p, input logic [7:0] h,
                         input logic st, input logic ab);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_pat   = p;
        in_hold  = h;
        start    = st;
        abort    = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [9:0] exp);
        logic [9:0] got;
        got = {a, b, s, busy, done, in_ready, count};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s #%0d got {abs,busy,done,rdy,cnt}=%b required=%b", nm, idx, got, exp);
        end
    endtask

    // Behavioural model: each popped entry expands into hold+1 per-cycle drive values.
    logic [2:0] mq_pat[$];
    int         mq_hold[$];
    logic [2:0] drv[$];
    logic       m_run;
    logic       m_done;
    logic [2:0] m_out;

    task automatic m_load();
        logic [2:0] p;
        int h;
        p = mq_pat.pop_front();
        h = mq_hold.pop_front();
        repeat (h + 1) drv.push_back(p);
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [2:0] p,
                              input int h, input logic st);
        int sz;
        sz = mq_pat.size();
        m_done = 1'b0;
        if (r) begin
            mq_pat.delete();
            mq_hold.delete();
            drv.delete();
            m_run = 1'b0;
            m_out = 3'b000;
            return;
        end
        if (!m_run) begin
            if (st && sz > 0) begin
                m_load();
                m_run = 1'b1;
            end
        end else begin
            void'(drv.pop_front());
            if (drv.size() == 0) begin
                if (sz > 0) m_load();
                else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        if (v && sz < DEPTH) begin
            mq_pat.push_back(p);
            mq_hold.push_back(h);
        end
        if (m_run) m_out = drv[0];
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pat = 3'b000; in_hold = 8'd0; start = 1'b0; abort = 1'b0;

        // reset with push/start offered: reset wins
        add(1, 1, 3'b111, 8'd3, 1, 0, 3'b000, 0, 0, 0);
        // two-entry playback: 011 x2, 100 x1, then done
        add(0, 1, 3'b011, 8'd1, 0, 0, 3'b000, 0, 0, 1);
        add(0, 1, 3'b100, 8'd0, 0, 0, 3'b000, 0, 0, 2);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b011, 1, 0, 1);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b011, 1, 0, 1);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b100, 1, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b100, 0, 1, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b100, 0, 0, 0);
        // start with empty FIFO is ignored
        add(1, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b000, 0, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        // fill to DEPTH, ninth offer refused, then start from full
        for (int i = 0; i < DEPTH; i++)
            add(0, 1, 3'(i), 8'd0, 0, 0, 3'b000, 0, 0, i + 1);
        add(0, 1, 3'b111, 8'd0, 0, 0, 3'b000, 0, 0, DEPTH);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b000, 1, 0, DEPTH - 1);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b001, 1, 0, DEPTH - 2);
        // push coincident with pop at count=2, start ignored in RUN
        add(1, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 3'b001, 8'd0, 0, 0, 3'b000, 0, 0, 1);
        add(0, 1, 3'b010, 8'd0, 0, 0, 3'b000, 0, 0, 2);
        add(0, 1, 3'b110, 8'd0, 0, 0, 3'b000, 0, 0, 3);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b001, 1, 0, 2);
        add(0, 1, 3'b101, 8'd0, 1, 0, 3'b010, 1, 0, 2);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b110, 1, 0, 1);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b101, 1, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b101, 0, 1, 0);
        // push into empty FIFO on the final edge does not extend playback
        add(1, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 3'b011, 8'd0, 0, 0, 3'b000, 0, 0, 1);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b011, 1, 0, 0);
        add(0, 1, 3'b100, 8'd1, 0, 0, 3'b011, 0, 1, 1);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b011, 0, 0, 1);
        // reset mid-hold abandons playback without done
        add(1, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 3'b111, 8'd5, 0, 0, 3'b000, 0, 0, 1);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b111, 1, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b111, 1, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b111, 1, 0, 0);
        add(1, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b000, 0, 0, 0);
`ifdef MUX_DRIVE_SEQ_ABORT_EN
        add(0, 1, 3'b001, 8'd2, 0, 0, 3'b000, 0, 0, 1);
        add(0, 1, 3'b010, 8'd2, 0, 0, 3'b000, 0, 0, 2);
        add(0, 1, 3'b011, 8'd2, 0, 0, 3'b000, 0, 0, 3);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b001, 1, 0, 2);
        add(0, 0, 3'b000, 8'd0, 0, 1, 3'b000, 0, 0, 0);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b000, 0, 0, 0);
        add(0, 1, 3'b100, 8'd0, 0, 1, 3'b000, 0, 0, 1);
        add(0, 0, 3'b000, 8'd0, 1, 0, 3'b100, 1, 0, 0);
        add(0, 0, 3'b000, 8'd0, 0, 0, 3'b100, 0, 1, 0);
`endif

        for (int i = 0; i < nvec_tbl; i++) begin
            apply(vecs[i].r, vecs[i].v, vecs[i].p, vecs[i].h, vecs[i].st, vecs[i].ab);
            check("table", i, {vecs[i].e_abs, vecs[i].e_busy, vecs[i].e_done,
                               vecs[i].e_rdy, vecs[i].e_cnt});
        end

        for (int i = 0; i < 3000; i++) begin
            logic       r, v, st;
            logic [2:0] p;
            int         h;
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 3) == 0);
            p  = 3'($urandom);
            h  = $urandom_range(0, 3);
            apply(r, v, p, 8'(h), st, 1'b0);
            model_edge(r, v, p, h, st);
            check("random", i, {m_out, m_run, m_done, (mq_pat.size() < DEPTH),
                                4'(mq_pat.size())});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mux_drive_seq.md
MUX_DRIVE_SEQ -- requirements
Module: mux_drive_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of pattern FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter HOLD_W, default 8, width of per-entry hold count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  pattern entry offered.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept an entry.
REQ-007 SHALL have port in_pat  input  3  entry drive value, bit2=a, bit1=b, bit0=s.
REQ-008 SHALL have port in_hold  input  HOLD_W  entry duration minus one, in cycles.
REQ-009 SHALL have port start  input  1  begin playback, single-cycle pulse.
REQ-010 SHALL have ports a, b, s  output  1 each  registered drive to the downstream 2:1 mux inputs.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of playback.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-014 SHALL buffer entries in a DEPTH-entry FIFO; push occurs on a rising edge with in_valid && in_ready.
REQ-015 SHALL drive in_ready = (count < DEPTH), registered-state only, with no combinational path from in_valid or start.
REQ-016 SHALL implement FSM states IDLE and RUN, plus a down-counter hold_cnt of HOLD_W bits.
REQ-017 IDLE: start && count>0 SHALL pop the head, load {a,b,s} from in_pat field, load hold_cnt=in_hold field, and enter RUN; outputs change one edge after start is sampled.
REQ-018 IDLE: start with count==0 SHALL be ignored (no state change, no done).
REQ-019 RUN: hold_cnt!=0 SHALL decrement hold_cnt and hold a, b, s unchanged.
REQ-020 RUN: hold_cnt==0 with count>0 SHALL pop the next entry and load outputs and hold_cnt, so each entry is driven exactly hold+1 cycles with no gap.
REQ-021 RUN: hold_cnt==0 with count==0 SHALL return to IDLE and pulse done for one cycle; a, b, s SHALL keep the last driven value.
REQ-022 start during RUN SHALL be ignored.
REQ-023 A simultaneous push and pop SHALL leave count unchanged, and the pushed entry SHALL be available to later pops; a push into an empty FIFO on the edge where hold_cnt reaches 0 SHALL not extend the current playback.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; a push when full SHALL be impossible, because in_ready is low.
REQ-025 busy SHALL equal (state==RUN).

Reset
REQ-026 rst high at a rising edge SHALL force IDLE, empty the FIFO (count=0), set hold_cnt=0, and set a=b=s=0, busy=0, done=0, in_ready=1.
REQ-027 rst asserted mid-RUN SHALL abandon playback without a done pulse; rst SHALL take priority over push, pop, and start on the same edge.

Configuration
REQ-028 Macro MUX_DRIVE_SEQ_ABORT_EN SHALL control an extra input port abort (1 bit).
REQ-029 With MUX_DRIVE_SEQ_ABORT_EN defined, abort high in RUN SHALL, on that edge, flush the FIFO, zero a, b, s and hold_cnt, and enter IDLE with no done pulse; abort SHALL be ignored in IDLE and SHALL lose priority to rst.
REQ-030 Without MUX_DRIVE_SEQ_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be exactly REQ-014..REQ-027.

Verification
REQ-031 Push {pat=3'b011,hold=1},{3'b100,hold=0}, then start -> a,b,s = 0,1,1 for 2 cycles, then 1,0,0 for 1 cycle; done pulses on the edge after; busy high for exactly 3 cycles.
REQ-032 Push 8 entries with in_valid held high -> in_ready=0 and count=8 after the 8th push; a 9th offered entry SHALL not be accepted.
REQ-033 start with an empty FIFO -> busy stays 0, done stays 0, and a,b,s remain 0.
REQ-034 During RUN with count=2, push on the same edge as a pop -> count remains 2, and the pushed pattern appears after the existing entries.
REQ-035 Assert rst two cycles into a hold=5 entry -> the next cycle shows a=b=s=0, count=0, busy=0, and no done pulse.
REQ-036 With MUX_DRIVE_SEQ_ABORT_EN: 3 entries queued, abort during the first -> IDLE next cycle, count=0, outputs 0, done=0; a later start is ignored until new pushes.
